// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencing FSM for the RISC-V core: fetch/decode/execute/memory/writeback
// with memory handshake timeouts, an illegal-instruction trap and a retired-instruction counter.
module multicycle_ctrl #(
    parameter int unsigned MAX_WAIT = 15,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       op,
    input  logic [2:0]       funct3,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             imem_req,
    output logic             ir_we,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             alu_src,
    output logic             reg_we,
    output logic [1:0]       wb_sel,
    output logic             pc_we,
    output logic [1:0]       pc_sel,
    output logic [2:0]       state,
    output logic             trap,
    output logic [1:0]       trap_cause,
    output logic [CNT_W-1:0] instret
);

    typedef enum logic [2:0] {
        StFetch  = 3'd0,
        StDecode = 3'd1,
        StExec   = 3'd2,
        StMem    = 3'd3,
        StWb     = 3'd4,
        StTrap   = 3'd5
    } state_e;

    typedef enum logic [2:0] {
        ClsNone    = 3'd0,
        ClsR       = 3'd1,
        ClsIalu    = 3'd2,
        ClsStore   = 3'd3,
        ClsJump    = 3'd4,
        ClsCust    = 3'd5,
        ClsIllegal = 3'd6
    } cls_e;

    localparam logic [1:0] CauseNone    = 2'd0;
    localparam logic [1:0] CauseIllegal = 2'd1;
    localparam logic [1:0] CauseImem    = 2'd2;
    localparam logic [1:0] CauseDmem    = 2'd3;

    // Last unanswered cycle before the timeout fires.
    localparam logic [7:0] WaitLast = 8'(MAX_WAIT - 1);

    state_e           state_q;
    cls_e             cls_q;
    cls_e             dec_cls;
    logic [7:0]       wait_q;
    logic             trap_q;
    logic [1:0]       cause_q;
    logic [CNT_W-1:0] instret_q;

    always_comb begin
        dec_cls = ClsIllegal;
        case (op)
            7'b0110011: if (funct3 inside {3'b000, 3'b010, 3'b111, 3'b101}) dec_cls = ClsR;
            7'b0010011: if (funct3 inside {3'b000, 3'b010, 3'b111}) dec_cls = ClsIalu;
            7'b0100011: if (funct3 == 3'b010) dec_cls = ClsStore;
            7'b0011011: dec_cls = ClsJump;
            7'b0001011: dec_cls = ClsCust;
            default:    dec_cls = ClsIllegal;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StFetch;
            cls_q     <= ClsNone;
            wait_q    <= '0;
            trap_q    <= 1'b0;
            cause_q   <= CauseNone;
            instret_q <= '0;
        end else begin
            case (state_q)
                StFetch: begin
                    if (imem_ready) begin
                        state_q <= StDecode;
                        wait_q  <= '0;
                    end else if (wait_q == WaitLast) begin
                        state_q <= StTrap;
                        trap_q  <= 1'b1;
                        cause_q <= CauseImem;
                        wait_q  <= '0;
                    end else begin
                        wait_q <= wait_q + 8'd1;
                    end
                end
                StDecode: begin
                    cls_q <= dec_cls;
                    if (dec_cls == ClsIllegal) begin
                        state_q <= StTrap;
                        trap_q  <= 1'b1;
                        cause_q <= CauseIllegal;
                    end else begin
                        state_q <= StExec;
                    end
                end
                StExec: begin
                    wait_q  <= '0;
                    state_q <= (cls_q == ClsStore) ? StMem : StWb;
                end
                StMem: begin
                    if (dmem_ready) begin
                        state_q   <= StFetch;
                        wait_q    <= '0;
                        instret_q <= instret_q + CNT_W'(1);
                    end else if (wait_q == WaitLast) begin
                        state_q <= StTrap;
                        trap_q  <= 1'b1;
                        cause_q <= CauseDmem;
                        wait_q  <= '0;
                    end else begin
                        wait_q <= wait_q + 8'd1;
                    end
                end
                StWb: begin
                    state_q   <= StFetch;
                    instret_q <= instret_q + CNT_W'(1);
                end
                StTrap: begin
                    state_q <= StTrap;
                end
                default: begin
                    state_q <= StTrap;
                    trap_q  <= 1'b1;
                    cause_q <= CauseIllegal;
                end
            endcase
        end
    end

    // Strobes are suppressed while reset is asserted so an abandoned WB/MEM never commits.
    always_comb begin
        imem_req = 1'b0;
        ir_we    = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        alu_src  = 1'b0;
        reg_we   = 1'b0;
        wb_sel   = 2'd0;
        pc_we    = 1'b0;
        pc_sel   = 2'd0;
        if (rst_n) begin
            case (state_q)
                StFetch: begin
                    imem_req = 1'b1;
                    ir_we    = imem_ready;
                end
                StExec: begin
                    alu_src = (cls_q != ClsR);
                end
                StMem: begin
                    dmem_req = 1'b1;
                    dmem_we  = 1'b1;
                    alu_src  = 1'b1;
                    pc_we    = dmem_ready;
                end
                StWb: begin
                    reg_we = 1'b1;
                    pc_we  = 1'b1;
                    if (cls_q == ClsJump) begin
                        wb_sel  = 2'd1;
                        pc_sel  = 2'd1;
                        alu_src = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign state      = state_q;
    assign trap       = trap_q;
    assign trap_cause = cause_q;
    assign instret    = instret_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: stimulus queues hand-computed per-cycle outputs,
// a negedge monitor pops and compares them against the DUT.
module tb_multicycle_ctrl;

    localparam logic [10:0] NONE  = 11'h000;
    localparam logic [10:0] IMREQ = 11'h400;
    localparam logic [10:0] IRWE  = 11'h200;
    localparam logic [10:0] DREQ  = 11'h100;
    localparam logic [10:0] DWE   = 11'h080;
    localparam logic [10:0] ALUS  = 11'h040;
    localparam logic [10:0] RWE   = 11'h020;
    localparam logic [10:0] WBS1  = 11'h008;
    localparam logic [10:0] PCWE  = 11'h004;
    localparam logic [10:0] PCS1  = 11'h001;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  op;
    logic [2:0]  funct3;
    logic        imem_ready;
    logic        dmem_ready;
    logic        imem_req;
    logic        ir_we;
    logic        dmem_req;
    logic        dmem_we;
    logic        alu_src;
    logic        reg_we;
    logic [1:0]  wb_sel;
    logic        pc_we;
    logic [1:0]  pc_sel;
    logic [2:0]  state;
    logic        trap;
    logic [1:0]  trap_cause;
    logic [31:0] instret;

    typedef struct packed {
        logic [15:0] idx;
        logic [2:0]  st;
        logic [10:0] sb;
        logic        tr;
        logic [1:0]  tc;
        logic [31:0] ic;
    } exp_t;

    exp_t q[$];
    int   cyc_n   = 0;
    int   n_check = 0;
    int   n_pass  = 0;

    multicycle_ctrl #(
        .MAX_WAIT(15),
        .CNT_W   (32)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .op        (op),
        .funct3    (funct3),
        .imem_ready(imem_ready),
        .dmem_ready(dmem_ready),
        .imem_req  (imem_req),
        .ir_we     (ir_we),
        .dmem_req  (dmem_req),
        .dmem_we   (dmem_we),
        .alu_src   (alu_src),
        .reg_we    (reg_we),
        .wb_sel    (wb_sel),
        .pc_we     (pc_we),
        .pc_sel    (pc_sel),
        .state     (state),
        .trap      (trap),
        .trap_cause(trap_cause),
        .instret   (instret)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            exp_t g;
            e = q.pop_front();
            g.idx = e.idx;
            g.st  = state;
            g.sb  = {imem_req, ir_we, dmem_req, dmem_we, alu_src, reg_we, wb_sel, pc_we, pc_sel};
            g.tr  = trap;
            g.tc  = trap_cause;
            g.ic  = instret;
            n_check++;
            if (g === e) begin
                n_pass++;
            end else begin
                $display("FAIL cyc%0d: got st=%0d sb=%b trap=%b cause=%0d instret=%0d, want st=%0d sb=%b trap=%b cause=%0d instret=%0d",
                         e.idx, g.st, g.sb, g.tr, g.tc, g.ic, e.st, e.sb, e.tr, e.tc, e.ic);
            end
        end
    end

    // Drive one cycle of inputs and queue the outputs expected during that cycle.
    task automatic cyc(input logic rn, input logic imr, input logic dmr, input logic [2:0] st,
                       input logic [10:0] sb, input logic tr, input logic [1:0] tc,
                       input logic [31:0] ic);
        exp_t e;
        rst_n      = rn;
        imem_ready = imr;
        dmem_ready = dmr;
        e.idx = 16'(cyc_n);
        e.st  = st;
        e.sb  = sb;
        e.tr  = tr;
        e.tc  = tc;
        e.ic  = ic;
        q.push_back(e);
        cyc_n++;
        @(posedge clk);
        #1;
    endtask

    // Zero-wait FETCH/DECODE/EXEC/WB; readies toggled in DECODE/EXEC must be ignored.
    task automatic instr4(input logic [6:0] o, input logic [2:0] f, input logic [10:0] ex_sb,
                          input logic [10:0] wb_sb, input logic [31:0] ic);
        op     = o;
        funct3 = f;
        cyc(1'b1, 1'b1, 1'b0, 3'd0, IMREQ | IRWE, 1'b0, 2'd0, ic);
        cyc(1'b1, 1'b1, 1'b1, 3'd1, NONE, 1'b0, 2'd0, ic);
        cyc(1'b1, 1'b0, 1'b1, 3'd2, ex_sb, 1'b0, 2'd0, ic);
        cyc(1'b1, 1'b0, 1'b0, 3'd4, wb_sb, 1'b0, 2'd0, ic);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
        $fatal(1);
    end

    initial begin
        rst_n      = 1'b0;
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        op         = 7'd0;
        funct3     = 3'd0;
        @(posedge clk);
        #1;
        // Reset held with readies high: no strobes at all.
        cyc(1'b0, 1'b1, 1'b1, 3'd0, NONE, 1'b0, 2'd0, 32'd0);

        instr4(7'b0110011, 3'b000, NONE, RWE | PCWE, 32'd0);

        // Store with three stalled MEM cycles.
        op     = 7'b0100011;
        funct3 = 3'b010;
        cyc(1'b1, 1'b1, 1'b0, 3'd0, IMREQ | IRWE, 1'b0, 2'd0, 32'd1);
        cyc(1'b1, 1'b0, 1'b0, 3'd1, NONE, 1'b0, 2'd0, 32'd1);
        cyc(1'b1, 1'b0, 1'b0, 3'd2, ALUS, 1'b0, 2'd0, 32'd1);
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, 3'd3, DREQ | DWE | ALUS, 1'b0, 2'd0, 32'd1);
        cyc(1'b1, 1'b0, 1'b1, 3'd3, DREQ | DWE | ALUS | PCWE, 1'b0, 2'd0, 32'd1);

        instr4(7'b0011011, 3'b101, ALUS, ALUS | RWE | WBS1 | PCWE | PCS1, 32'd2);
        instr4(7'b0010011, 3'b000, ALUS, RWE | PCWE, 32'd3);
        instr4(7'b0001011, 3'b011, ALUS, RWE | PCWE, 32'd4);
        instr4(7'b0110011, 3'b101, NONE, RWE | PCWE, 32'd5);

        // Illegal IALU funct3 traps after DECODE and stays put.
        op     = 7'b0010011;
        funct3 = 3'b001;
        cyc(1'b1, 1'b1, 1'b0, 3'd0, IMREQ | IRWE, 1'b0, 2'd0, 32'd6);
        cyc(1'b1, 1'b0, 1'b0, 3'd1, NONE, 1'b0, 2'd0, 32'd6);
        for (int i = 0; i < 20; i++) begin
            cyc(1'b1, 1'(i % 2), 1'(1 - i % 2), 3'd5, NONE, 1'b1, 2'd1, 32'd6);
        end
        cyc(1'b0, 1'b0, 1'b0, 3'd5, NONE, 1'b1, 2'd1, 32'd6);

        // Instruction memory never answers: 15 FETCH cycles then TRAP cause 2.
        for (int i = 0; i < 15; i++) cyc(1'b1, 1'b0, 1'b0, 3'd0, IMREQ, 1'b0, 2'd0, 32'd0);
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b1, 3'd5, NONE, 1'b1, 2'd2, 32'd0);
        cyc(1'b0, 1'b0, 1'b0, 3'd5, NONE, 1'b1, 2'd2, 32'd0);
        cyc(1'b1, 1'b0, 1'b0, 3'd0, IMREQ, 1'b0, 2'd0, 32'd0);

        // Reset during MEM with dmem_ready high: no commit.
        op     = 7'b0100011;
        funct3 = 3'b010;
        cyc(1'b1, 1'b1, 1'b0, 3'd0, IMREQ | IRWE, 1'b0, 2'd0, 32'd0);
        cyc(1'b1, 1'b0, 1'b0, 3'd1, NONE, 1'b0, 2'd0, 32'd0);
        cyc(1'b1, 1'b0, 1'b0, 3'd2, ALUS, 1'b0, 2'd0, 32'd0);
        cyc(1'b1, 1'b0, 1'b0, 3'd3, DREQ | DWE | ALUS, 1'b0, 2'd0, 32'd0);
        cyc(1'b0, 1'b0, 1'b1, 3'd3, NONE, 1'b0, 2'd0, 32'd0);
        cyc(1'b1, 1'b0, 1'b1, 3'd0, IMREQ, 1'b0, 2'd0, 32'd0);

        // Reset during WB: no reg_we/pc_we.
        op     = 7'b0110011;
        funct3 = 3'b111;
        cyc(1'b1, 1'b1, 1'b0, 3'd0, IMREQ | IRWE, 1'b0, 2'd0, 32'd0);
        cyc(1'b1, 1'b0, 1'b0, 3'd1, NONE, 1'b0, 2'd0, 32'd0);
        cyc(1'b1, 1'b0, 1'b0, 3'd2, NONE, 1'b0, 2'd0, 32'd0);
        cyc(1'b0, 1'b0, 1'b0, 3'd4, NONE, 1'b0, 2'd0, 32'd0);
        cyc(1'b1, 1'b0, 1'b0, 3'd0, IMREQ, 1'b0, 2'd0, 32'd0);
        cyc(1'b1, 1'b0, 1'b0, 3'd0, IMREQ, 1'b0, 2'd0, 32'd0);

        instr4(7'b0110011, 3'b010, NONE, RWE | PCWE, 32'd0);
        cyc(1'b1, 1'b0, 1'b0, 3'd0, IMREQ, 1'b0, 2'd0, 32'd1);

        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            n_check++;
            $display("FAIL drain: got %0d unchecked entries, want 0", q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_check);
        $finish;
    end

endmodule
